multicycle_control: RTL
=======================

# multicycle_control

Multicycle MIPS control unit. It sequences the shared datapath (single memory, ALU, PC register, IR, and the sign-extend/shift-left-two branch-offset path) through fetch, decode, execute, memory and writeback states. It drives every mux select and write strobe, and inserts wait states whenever memory is not ready. It sits beside the datapath top level and takes only the IR opcode field plus a memory-ready handshake.

## Interface
- No parameters. Opcode and state encodings are fixed below.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state FETCH
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- i_or_d  output  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination: 0 = rt, 1 = rd
- reg_write  output  1  register file write
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state, for debug
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3
  - MEM_WB = 4, MEM_WRITE = 5, EXECUTE = 6, ALU_WB = 7
  - BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11
  - Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Opcodes:
  - R-type = 000000, lw = 100011, sw = 101011
  - beq = 000100, j = 000010, addi = 001000
- Outputs are decoded from state (Moore). The exceptions are ir_write, pc_write in FETCH, and the advance out of the memory states, which are qualified by mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00; ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state: lw/sw → MEM_ADDR, R-type → EXECUTE, beq → BRANCH, j → JUMP, addi → ADDI_EX.
  - Any other opcode → FETCH with illegal_op = 1 and instr_done = 1.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1 → FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Holds until mem_ready; on mem_ready, instr_done = 1 → FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10 → ALU_WB.
- ALU_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1 → FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, instr_done = 1 → FETCH.
- JUMP: pc_write = 1, pc_source = 10, instr_done = 1 → FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00 → ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1 → FETCH.

## Timing
- Reset:
  - Asynchronous assertion sets state to FETCH immediately.
  - While reset is high, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op) are 0.
  - While reset is high, the selects hold their FETCH values: i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00, mem_to_reg = 0, reg_dst = 0.
  - Reset mid-instruction abandons it; no partial writeback occurs after reset rises.
  - The first FETCH read request appears in the cycle after reset deasserts.
- Latency with mem_ready held at 1:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j = 3 cycles
  - Each mem_ready = 0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Memory handshake: the request (mem_read/mem_write) and its address select stay stable across every wait cycle. Write strobes fire only in the ready cycle, exactly once per access.
- opcode is sampled only in DECODE and MEM_ADDR; changes on it in other states are ignored.
- instr_done and illegal_op are never high for more than one consecutive cycle.

## Test plan
- lw, mem_ready = 1 → state sequence 0, 1, 2, 3, 4, 0. reg_write = 1 and mem_to_reg = 1 in cycle 5 only. instr_done pulses in cycle 5.
- sw, with mem_ready = 0 for 3 cycles in MEM_WRITE → state 5 lasts 4 cycles. mem_write = 1 and i_or_d = 1 throughout. instr_done appears only in the ready cycle. Total 7 cycles.
- Fetch stall, mem_ready low for 2 cycles in FETCH → ir_write = pc_write = 0 for 2 cycles, then both = 1 for one cycle, then state 1.
- beq then j back-to-back → beq: 0, 1, 8 with pc_write_cond = 1 and pc_source = 01 in state 8. j: 0, 1, 9 with pc_write = 1 and pc_source = 10.
- opcode 111111 in DECODE → illegal_op = 1 and instr_done = 1 for one cycle; next state 0; no reg_write or mem_write at any point.
- Reset asserted asynchronously mid-clock while in MEM_WB → state becomes 0 before the next edge, with reg_write = 0. After release, a normal fetch proceeds.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-to-datapath bundle for the multicycle MIPS controller
//   master: controller side (drives strobes/selects, reads opcode and mem_ready)
//   slave : datapath side (drives opcode and mem_ready, reads strobes/selects)
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op
    );
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with memory wait states
//   clk, reset (async, active-high) plain ports; bus (master) carries opcode,
//   mem_ready and every datapath strobe/select plus state, instr_done, illegal_op
module multicycle_control (
    input logic               clk,
    input logic               reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       done;
    } ctl_t;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    state_t st, nxt;
    ctl_t   c;
    logic   legal, ir_write;
    function automatic ctl_t outs(input state_t s);
        ctl_t o;
        o = '0;
        case (s)
            FETCH:     begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; end
            DECODE:    o.alu_src_b = 2'b11;
            MEM_ADDR:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            MEM_READ:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
            MEM_WB:    begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.done = 1'b1; end
            MEM_WRITE: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
            EXECUTE:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            ALU_WB:    begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.done = 1'b1; end
            BRANCH:    begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
                o.pc_source = 2'b01; o.done = 1'b1;
            end
            JUMP:      begin o.pc_write = 1'b1; o.pc_source = 2'b10; o.done = 1'b1; end
            ADDI_EX:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            ADDI_WB:   begin o.reg_write = 1'b1; o.done = 1'b1; end
            default:   o = '0;
        endcase
        return o;
    endfunction
    assign legal = bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    // FETCH only advances once its read request is actually on the bus; right
    // after reset the registered request is still low for one cycle.
    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:     nxt = (bus.mem_ready && c.mem_read) ? DECODE : FETCH;
            DECODE:    nxt = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADDR :
                             (bus.opcode == OP_R)    ? EXECUTE :
                             (bus.opcode == OP_BEQ)  ? BRANCH  :
                             (bus.opcode == OP_J)    ? JUMP    :
                             (bus.opcode == OP_ADDI) ? ADDI_EX : FETCH;
            MEM_ADDR:  nxt = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  nxt = bus.mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: nxt = bus.mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   nxt = ALU_WB;
            ADDI_EX:   nxt = ADDI_WB;
            default:   nxt = FETCH;
        endcase
    end
    // Moore outputs are registered from the next state so they line up with st.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= FETCH;
            c           <= '0;
            c.alu_src_b <= 2'b01;
        end else begin
            st <= nxt;
            c  <= outs(nxt);
        end
    end
    assign ir_write          = (st == FETCH) && c.mem_read && bus.mem_ready;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = c.pc_write | ir_write;
    assign bus.pc_write_cond = c.pc_write_cond;
    assign bus.i_or_d        = c.i_or_d;
    assign bus.mem_read      = c.mem_read;
    assign bus.mem_write     = c.mem_write;
    assign bus.mem_to_reg    = c.mem_to_reg;
    assign bus.reg_dst       = c.reg_dst;
    assign bus.reg_write     = c.reg_write;
    assign bus.alu_src_a     = c.alu_src_a;
    assign bus.alu_src_b     = c.alu_src_b;
    assign bus.alu_op        = c.alu_op;
    assign bus.pc_source     = c.pc_source;
    assign bus.state         = st;
    assign bus.illegal_op    = (st == DECODE) && !legal;
    assign bus.instr_done    = c.done | ((st == MEM_WRITE) && bus.mem_ready) | bus.illegal_op;
endmodule
